// File: rtl/stream_serializer_pkg.sv
// Shared types and sizing helpers for the parallel-to-serial feeder
// that drives the sequence detector input.
package stream_serializer_pkg;

  localparam int DEFAULT_NUM_BITS = 8;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  // Bit counter width for a 0..n-1 count; n is at least 2.
  function automatic int cnt_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/shift_reg_pts.sv
// Parallel-load, shift-enable register; exposes the bit at the output end
// (MSB when SHIFT_MSB, otherwise LSB).
module shift_reg_pts #(
  parameter int NUM_BITS  = 8,
  parameter bit SHIFT_MSB = 1'b1
) (
  input  logic                clk,
  input  logic                n_rst,
  input  logic                load,
  input  logic [NUM_BITS-1:0] load_data,
  input  logic                shift_en,
  output logic                out_bit
);

  logic [NUM_BITS-1:0] q;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of block ordering.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      q <= '0;
    end else if (load) begin
      q <= load_data;
    end else if (shift_en) begin
      q <= SHIFT_MSB ? {q[NUM_BITS-2:0], 1'b0} : {1'b0, q[NUM_BITS-1:1]};
    end
  end

  assign out_bit = SHIFT_MSB ? q[NUM_BITS-1] : q[0];

endmodule

// File: rtl/stream_serializer.sv
// Double-buffered parallel-to-serial feeder: a holding register accepts the
// next word while the shift register presents the current one bit per strobe.
module stream_serializer
  import stream_serializer_pkg::*;
#(
  parameter int NUM_BITS  = DEFAULT_NUM_BITS,
  parameter bit SHIFT_MSB = 1'b1,
  parameter bit IDLE_BIT  = 1'b0
) (
  input  logic                clk,
  input  logic                n_rst,
  input  logic [NUM_BITS-1:0] data_in,
  input  logic                data_valid,
  output logic                data_ready,
  input  logic                shift_strobe,
  output logic                serial_out,
  output logic                bit_valid,
  output logic                word_done
);

  localparam int            CW       = cnt_w(NUM_BITS);
  localparam logic [CW-1:0] LAST_CNT = CW'(NUM_BITS - 1);

  state_t              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [NUM_BITS-1:0] hold_reg;
  logic                hold_full;
  logic                load_sr, shift_sr, done_d, sr_bit, accept;

  // Holding and reload are mutually exclusive: accept needs ~hold_full,
  // reload needs hold_full.
  assign accept     = data_valid && !hold_full;
  assign data_ready = !hold_full;

  // NOTE: every output of this block gets a default first so no path leaves
  // a signal unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    load_sr  = 1'b0;
    shift_sr = 1'b0;
    done_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (hold_full) begin
          load_sr = 1'b1;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (shift_strobe) begin
          if (cnt_q == LAST_CNT) begin
            done_d = 1'b1;
            if (hold_full) begin
              load_sr = 1'b1;
              cnt_d   = '0;
            end else begin
              state_d = IDLE;
            end
          end else begin
            shift_sr = 1'b1;
            cnt_d    = cnt_q + CW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      hold_full <= 1'b0;
      word_done <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      word_done <= done_d;
      if (load_sr) begin
        hold_full <= 1'b0;
      end else if (accept) begin
        hold_full <= 1'b1;
      end
    end
  end

  // NOTE: hold_reg is pure data qualified by hold_full, so it carries no
  // reset; a discarded word simply becomes unreachable.
  always_ff @(posedge clk) begin
    if (accept) begin
      hold_reg <= data_in;
    end
  end

  shift_reg_pts #(
    .NUM_BITS (NUM_BITS),
    .SHIFT_MSB(SHIFT_MSB)
  ) u_sr (
    .clk      (clk),
    .n_rst    (n_rst),
    .load     (load_sr),
    .load_data(hold_reg),
    .shift_en (shift_sr),
    .out_bit  (sr_bit)
  );

  assign bit_valid  = (state_q == SHIFT);
  assign serial_out = bit_valid ? sr_bit : IDLE_BIT;

endmodule

// File: tb/tb_stream_serializer.sv
// Directed bench: an MSB-first and an LSB-first instance share all inputs;
// each step checks serial data, handshake and word_done against hand values.
module tb_stream_serializer;

  logic       clk = 1'b0;
  logic       n_rst;
  logic [7:0] data_in;
  logic       data_valid;
  logic       shift_strobe;
  logic       dr_m, so_m, bv_m, wd_m;
  logic       dr_l, so_l, bv_l, wd_l;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  stream_serializer #(.NUM_BITS(8), .SHIFT_MSB(1'b1), .IDLE_BIT(1'b0)) dut_msb (
    .clk(clk), .n_rst(n_rst), .data_in(data_in), .data_valid(data_valid),
    .data_ready(dr_m), .shift_strobe(shift_strobe), .serial_out(so_m),
    .bit_valid(bv_m), .word_done(wd_m)
  );

  stream_serializer #(.NUM_BITS(8), .SHIFT_MSB(1'b0), .IDLE_BIT(1'b0)) dut_lsb (
    .clk(clk), .n_rst(n_rst), .data_in(data_in), .data_valid(data_valid),
    .data_ready(dr_l), .shift_strobe(shift_strobe), .serial_out(so_l),
    .bit_valid(bv_l), .word_done(wd_l)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a word and hold it until accepted (bounded); returns in cycle k.
  task automatic push(input logic [7:0] w);
    int n = 0;
    while (!dr_m && n < 50) begin
      tick();
      n++;
    end
    check("push_ready", {31'b0, dr_m}, 32'd1);
    data_in    = w;
    data_valid = 1'b1;
    tick();
    data_valid = 1'b0;
  endtask

  // Strobe tied high: bits in cycles k+1..k+8, word_done in k+9.
  task automatic send_check(input logic [7:0] w);
    push(w);
    check($sformatf("ready_low_%0h", w), {31'b0, dr_m}, 32'd0);
    for (int n = 0; n < 8; n++) begin
      tick();
      check($sformatf("msb_%0h_b%0d", w, n), {31'b0, so_m}, {31'b0, w[7-n]});
      check($sformatf("lsb_%0h_b%0d", w, n), {31'b0, so_l}, {31'b0, w[n]});
      check($sformatf("bv_%0h_b%0d", w, n), {30'b0, bv_m, bv_l}, 32'd3);
      check($sformatf("wd_%0h_b%0d", w, n), {30'b0, wd_m, wd_l}, 32'd0);
    end
    tick();
    check($sformatf("done_%0h", w), {30'b0, wd_m, wd_l}, 32'd3);
    check($sformatf("idle_after_%0h", w), {29'b0, bv_m, bv_l, so_m}, 32'd0);
    tick();
    check($sformatf("done_pulse_%0h", w), {30'b0, wd_m, wd_l}, 32'd0);
  endtask

  initial begin
    logic [7:0]  w;
    logic [23:0] rx;
    int          nbits, dones, first_v, last_v, idx;
    int          acc_cyc[3];
    logic [23:0] queued;
    logic        acc, seen;

    n_rst        = 1'b0;
    data_in      = '0;
    data_valid   = 1'b0;
    shift_strobe = 1'b1;

    // Reset values, then idle behaviour
    #2;
    check("rst_outputs", {28'b0, so_m, bv_m, wd_m, dr_m}, 32'h1);
    #10 n_rst = 1'b1;
    repeat (10) tick();
    check("idle_outputs", {28'b0, so_m, bv_m, wd_m, dr_m}, 32'h1);

    // Async reset mid-cycle while idle returns immediately
    #2 n_rst = 1'b0;
    #1 check("async_rst_idle", {28'b0, so_m, bv_m, wd_m, dr_m}, 32'h1);
    @(posedge clk);
    #3 n_rst = 1'b1;
    tick();

    // Single word D0 (MSB: 1,1,0,1,0,0,0,0)
    send_check(8'hD0);

    // Back-to-back B4 then 6D: 16 contiguous bits, done pulses 8 apart
    push(8'hB4);
    data_in    = 8'h6D;
    data_valid = 1'b1;
    for (int n = 0; n < 16; n++) begin
      tick();
      if (n == 1) data_valid = 1'b0;
      w = (n < 8) ? 8'hB4 : 8'h6D;
      check($sformatf("b2b_msb_%0d", n), {31'b0, so_m}, {31'b0, w[7-(n%8)]});
      check($sformatf("b2b_lsb_%0d", n), {31'b0, so_l}, {31'b0, w[n%8]});
      check($sformatf("b2b_bv_%0d", n), {31'b0, bv_m}, 32'd1);
      check($sformatf("b2b_wd_%0d", n), {31'b0, wd_m}, (n == 8) ? 32'd1 : 32'd0);
    end
    tick();
    check("b2b_done2", {30'b0, wd_m, bv_m}, 32'd2);
    tick();
    check("b2b_done2_pulse", {31'b0, wd_m}, 32'd0);

    // data_valid held high with three queued words
    queued     = 24'h112233;
    idx        = 0;
    rx         = '0;
    nbits      = 0;
    dones      = 0;
    first_v    = -1;
    last_v     = -1;
    data_in    = queued[23:16];
    data_valid = 1'b1;
    for (int c = 0; c < 40; c++) begin
      acc = data_valid && dr_m;
      tick();
      if (acc) begin
        acc_cyc[idx] = c;
        idx++;
        if (idx == 3) data_valid = 1'b0;
        else data_in = queued[23-8*idx -: 8];
      end
      if (bv_m) begin
        rx = {rx[22:0], so_m};
        nbits++;
        if (first_v < 0) first_v = c;
        last_v = c;
      end
      if (wd_m) dones++;
    end
    data_valid = 1'b0;
    check("q_accepts", idx, 32'd3);
    check("q_acc0", acc_cyc[0], 32'd0);
    check("q_acc1", acc_cyc[1], 32'd2);
    check("q_acc2", acc_cyc[2], 32'd10);
    check("q_nbits", nbits, 32'd24);
    check("q_data", {8'b0, rx}, 32'h112233);
    check("q_contig", last_v - first_v, 32'd23);
    check("q_dones", dones, 32'd3);

    // Strobe every 3rd cycle, A5 (MSB: 1,0,1,0,0,1,0,1)
    shift_strobe = 1'b0;
    push(8'hA5);
    tick();
    for (int j = 0; j < 24; j++) begin
      check($sformatf("slow_msb_%0d", j), {31'b0, so_m}, {31'b0, queued_bit(8'hA5, 7 - j/3)});
      check($sformatf("slow_lsb_%0d", j), {31'b0, so_l}, {31'b0, queued_bit(8'hA5, j/3)});
      check($sformatf("slow_bv_%0d", j), {31'b0, bv_m}, 32'd1);
      shift_strobe = (j % 3 == 2);
      tick();
    end
    check("slow_done", {30'b0, wd_m, bv_m}, 32'd2);
    shift_strobe = 1'b1;
    tick();

    // Reset after 4 bits of FF with 5A held: both discarded, no word_done
    push(8'hFF);
    tick();
    data_in    = 8'h5A;
    data_valid = 1'b1;
    tick();
    data_valid = 1'b0;
    check("mid_hold_full", {31'b0, dr_m}, 32'd0);
    tick();
    tick();
    check("mid_bit4", {30'b0, so_m, bv_m}, 32'd3);
    #2 n_rst = 1'b0;
    #1 check("mid_async_rst", {28'b0, so_m, bv_m, wd_m, dr_m}, 32'h1);
    check("mid_async_rst_l", {28'b0, so_l, bv_l, wd_l, dr_l}, 32'h1);
    @(posedge clk);
    #3 n_rst = 1'b1;
    seen = 1'b0;
    repeat (12) begin
      tick();
      seen = seen | wd_m | bv_m | wd_l | bv_l;
    end
    check("mid_discarded", {31'b0, seen}, 32'd0);
    send_check(8'h3C);

    // LSB-first instance on 0B: 1,1,0,1,0,0,0,0
    send_check(8'h0B);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  function automatic logic queued_bit(input logic [7:0] w, input int i);
    return w[i];
  endfunction

endmodule
